// File: rtl/riscv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_pkg : load/store funct3 encodings and writeback FSM state type
// Rev 1.0
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_MEM_REQ = 2'd1,
    WB_DONE    = 2'd2
  } wb_state_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_align : store lane/byte-enable steering, load extraction/extension,
//             and alignment check for a 32-bit data bus
// Rev 1.0
// ---------------------------------------------------------------------------
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_fmt_o,
  output logic        misaligned_o
);

  logic [31:0] w_shifted;
  logic [15:0] w_half;

  assign w_shifted = load_data_i >> {addr_lo_i, 3'b000};
  assign w_half    = addr_lo_i[1] ? load_data_i[31:16] : load_data_i[15:0];

  always_comb begin
    case (funct3_i)
      F3_LB:   load_fmt_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   load_fmt_o = {{16{w_half[15]}}, w_half};
      F3_LBU:  load_fmt_o = {24'd0, w_shifted[7:0]};
      F3_LHU:  load_fmt_o = {16'd0, w_half};
      default: load_fmt_o = load_data_i;
    endcase
  end

  // Access size lives in funct3[1:0] for both loads and stores
  always_comb begin
    case (funct3_i[1:0])
      F3_SB[1:0]: begin
        be_o         = 4'b0001 << addr_lo_i;
        wdata_o      = {4{store_data_i[7:0]}};
        misaligned_o = 1'b0;
      end
      F3_SH[1:0]: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        be_o         = 4'b1111;
        wdata_o      = store_data_i;
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/writeback.sv
`default_nettype none
// ---------------------------------------------------------------------------
// writeback : retires ALU results and performs one data-memory access per
//             load/store through an IDLE/MEM_REQ/DONE handshake
// Rev 1.0
// ---------------------------------------------------------------------------
module writeback
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        resetb,
  input  logic        wb_valid_in,
  output logic        wb_ready_out,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_addr,
  input  logic        ex_memwr,
  input  logic        ex_mem2reg,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_dst_sel,
  input  logic        ex_wb_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        wb_misaligned
);

  wb_state_e   state_q;
  logic        dmem_req_q, dmem_we_q, reg_we_q, misaligned_q;
  logic [31:0] dmem_addr_q, dmem_wdata_q, reg_wdata_q;
  logic [3:0]  dmem_be_q;
  logic [4:0]  reg_waddr_q;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_addr_lo_q;
  logic [4:0]  ld_rd_q;
  logic        ld_wr_q;

  logic        w_idle, w_is_mem, w_rd_ok;
  logic [2:0]  w_al_funct3;
  logic [1:0]  w_al_addr_lo;
  logic [3:0]  w_al_be;
  logic [31:0] w_al_wdata, w_al_load;
  logic        w_al_misaligned;

  assign w_idle   = (state_q == WB_IDLE);
  assign w_is_mem = ex_memwr | ex_mem2reg;
  assign w_rd_ok  = ex_wb_en & (|ex_dst_sel);

  // The aligner sees live execute fields while idle, latched ones while a load is in flight
  assign w_al_funct3  = w_idle ? ex_funct3    : ld_funct3_q;
  assign w_al_addr_lo = w_idle ? ex_addr[1:0] : ld_addr_lo_q;

  lsu_align u_lsu_align (
    .funct3_i     (w_al_funct3),
    .addr_lo_i    (w_al_addr_lo),
    .store_data_i (ex_result),
    .load_data_i  (dmem_rdata),
    .be_o         (w_al_be),
    .wdata_o      (w_al_wdata),
    .load_fmt_o   (w_al_load),
    .misaligned_o (w_al_misaligned)
  );

  always_ff @(posedge clk) begin
    if (resetb) begin
      state_q      <= WB_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      dmem_be_q    <= 4'd0;
      reg_we_q     <= 1'b0;
      reg_waddr_q  <= 5'd0;
      reg_wdata_q  <= 32'd0;
      misaligned_q <= 1'b0;
      ld_funct3_q  <= 3'd0;
      ld_addr_lo_q <= 2'd0;
      ld_rd_q      <= 5'd0;
      ld_wr_q      <= 1'b0;
    end else begin
      reg_we_q     <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        WB_IDLE: begin
          if (wb_valid_in) begin
            if (!w_is_mem) begin
              reg_we_q    <= w_rd_ok;
              reg_waddr_q <= ex_dst_sel;
              reg_wdata_q <= ex_result;
            end else if (w_al_misaligned) begin
              misaligned_q <= 1'b1;
            end else begin
              state_q      <= WB_MEM_REQ;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= ex_memwr;
              dmem_addr_q  <= {ex_addr[31:2], 2'b00};
              dmem_be_q    <= w_al_be;
              dmem_wdata_q <= w_al_wdata;
              ld_funct3_q  <= ex_funct3;
              ld_addr_lo_q <= ex_addr[1:0];
              ld_rd_q      <= ex_dst_sel;
              ld_wr_q      <= ~ex_memwr & w_rd_ok;
            end
          end
        end
        WB_MEM_REQ: begin
          if (dmem_ack) begin
            state_q    <= WB_DONE;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= ld_wr_q;
            if (ld_wr_q) begin
              reg_waddr_q <= ld_rd_q;
              reg_wdata_q <= w_al_load;
            end
          end
        end
        WB_DONE: state_q <= WB_IDLE;
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  assign wb_ready_out  = w_idle;
  assign dmem_req      = dmem_req_q;
  assign dmem_we       = dmem_we_q;
  assign dmem_addr     = dmem_addr_q;
  assign dmem_wdata    = dmem_wdata_q;
  assign dmem_be       = dmem_be_q;
  assign reg_we        = reg_we_q;
  assign reg_waddr     = reg_waddr_q;
  assign reg_wdata     = reg_wdata_q;
  assign wb_misaligned = misaligned_q;

endmodule : writeback
`default_nettype wire

// File: tb/tb_writeback.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_writeback : directed vector table, corner sequences and random traffic
//                against a behavioural model of the writeback stage
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_writeback;

  typedef struct {
    logic        memwr;
    logic        mem2reg;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        wb_en;
    int          dly;
    logic        exp_mis;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_daddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_dwdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetb = 1'b1;
  logic        wb_valid_in = 1'b0;
  logic        wb_ready_out;
  logic [31:0] ex_result = '0, ex_addr = '0;
  logic        ex_memwr = 1'b0, ex_mem2reg = 1'b0, ex_wb_en = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [4:0]  ex_dst_sel = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        wb_misaligned;

  int n_cmp = 0;
  int n_err = 0;

  writeback dut (
    .clk(clk), .resetb(resetb), .wb_valid_in(wb_valid_in), .wb_ready_out(wb_ready_out),
    .ex_result(ex_result), .ex_addr(ex_addr), .ex_memwr(ex_memwr), .ex_mem2reg(ex_mem2reg),
    .ex_funct3(ex_funct3), .ex_dst_sel(ex_dst_sel), .ex_wb_en(ex_wb_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .wb_misaligned(wb_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t vi(input logic memwr, input logic mem2reg, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] rdata, input logic [4:0] rd,
                              input logic wb_en, input int dly);
    vec_t v;
    v.memwr = memwr; v.mem2reg = mem2reg; v.f3 = f3; v.addr = addr; v.data = data;
    v.rdata = rdata; v.rd = rd; v.wb_en = wb_en; v.dly = dly;
    v.exp_mis = 1'b0; v.exp_we = 1'b0; v.exp_wdata = '0; v.exp_daddr = '0;
    v.exp_be = '0; v.exp_dwdata = '0;
    return v;
  endfunction

  function automatic vec_t ve(input vec_t v, input logic mis, input logic we,
                              input logic [31:0] wdata, input logic [31:0] daddr,
                              input logic [3:0] be, input logic [31:0] dwdata);
    vec_t e = v;
    e.exp_mis = mis; e.exp_we = we; e.exp_wdata = wdata;
    e.exp_daddr = daddr; e.exp_be = be; e.exp_dwdata = dwdata;
    return e;
  endfunction

  // Reference: derive everything from access size, byte offset and arithmetic masks
  function automatic vec_t model(input vec_t v);
    vec_t        e = v;
    int          size, off;
    logic [31:0] mask, raw;
    size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(v.addr[1:0]);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    e.exp_mis    = (v.memwr | v.mem2reg) && ((v.addr & 32'(size - 1)) != 0);
    e.exp_daddr  = v.addr - 32'(off);
    e.exp_be     = 4'(((1 << size) - 1) << off);
    e.exp_dwdata = (size == 1) ? (v.data & 32'hFF) * 32'h0101_0101 :
                   (size == 2) ? (v.data & 32'hFFFF) * 32'h0001_0001 : v.data;
    raw = (v.rdata >> (8 * off)) & mask;
    if (!v.f3[2] && size < 4 && raw[8 * size - 1]) raw = raw | ~mask;
    e.exp_wdata = (v.mem2reg && !v.memwr) ? raw : v.data;
    e.exp_we    = !e.exp_mis && !v.memwr && v.wb_en && (v.rd != 5'd0);
    return e;
  endfunction

  task automatic drive(input vec_t v);
    ex_memwr = v.memwr; ex_mem2reg = v.mem2reg; ex_funct3 = v.f3; ex_addr = v.addr;
    ex_result = v.data; ex_dst_sel = v.rd; ex_wb_en = v.wb_en;
  endtask

  task automatic wait_ready(input string nm);
    int t = 0;
    while (!wb_ready_out && t < 20) begin
      step();
      t++;
    end
    chk({nm, "_ready_timeout"}, {31'd0, wb_ready_out}, 32'd1);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    wait_ready(nm);
    drive(v);
    wb_valid_in = 1'b1;
    step();
    wb_valid_in = 1'b0;
    if (v.exp_mis) begin
      chk({nm, "_mis"}, {31'd0, wb_misaligned}, 32'd1);
      chk({nm, "_mis_req"}, {31'd0, dmem_req}, 32'd0);
      chk({nm, "_mis_we"}, {31'd0, reg_we}, 32'd0);
      step();
      chk({nm, "_mis_pulse"}, {31'd0, wb_misaligned}, 32'd0);
      chk({nm, "_mis_req2"}, {31'd0, dmem_req}, 32'd0);
    end else if (!(v.memwr | v.mem2reg)) begin
      chk({nm, "_alu_we"}, {31'd0, reg_we}, {31'd0, v.exp_we});
      if (v.exp_we) begin
        chk({nm, "_alu_waddr"}, {27'd0, reg_waddr}, {27'd0, v.rd});
        chk({nm, "_alu_wdata"}, reg_wdata, v.exp_wdata);
      end
      chk({nm, "_alu_req"}, {31'd0, dmem_req}, 32'd0);
      chk({nm, "_alu_ready"}, {31'd0, wb_ready_out}, 32'd1);
    end else begin
      for (int i = 0; i <= v.dly; i++) begin
        if (i > 0) step();
        chk({nm, "_req"}, {31'd0, dmem_req}, 32'd1);
        chk({nm, "_daddr"}, dmem_addr, v.exp_daddr);
        chk({nm, "_dwe"}, {31'd0, dmem_we}, {31'd0, v.memwr});
        if (v.memwr) begin
          chk({nm, "_be"}, {28'd0, dmem_be}, {28'd0, v.exp_be});
          chk({nm, "_dwdata"}, dmem_wdata, v.exp_dwdata);
        end
        chk({nm, "_busy_we"}, {31'd0, reg_we}, 32'd0);
        chk({nm, "_busy_ready"}, {31'd0, wb_ready_out}, 32'd0);
      end
      dmem_ack = 1'b1;
      dmem_rdata = v.rdata;
      step();
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      chk({nm, "_done_req"}, {31'd0, dmem_req}, 32'd0);
      chk({nm, "_done_we"}, {31'd0, reg_we}, {31'd0, v.exp_we});
      if (v.exp_we) begin
        chk({nm, "_done_waddr"}, {27'd0, reg_waddr}, {27'd0, v.rd});
        chk({nm, "_done_wdata"}, reg_wdata, v.exp_wdata);
      end
      chk({nm, "_done_ready"}, {31'd0, wb_ready_out}, 32'd0);
      step();
      chk({nm, "_post_ready"}, {31'd0, wb_ready_out}, 32'd1);
      chk({nm, "_post_we"}, {31'd0, reg_we}, 32'd0);
    end
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    tbl[0]  = ve(vi(0, 0, 3'b000, 32'h0,   32'h0000_0005, 32'h0,         5'd3, 1, 0), 0, 1, 32'h0000_0005, 32'h0,   4'h0,    32'h0);
    tbl[1]  = ve(vi(0, 1, 3'b000, 32'h103, 32'h0,         32'h80FF_1234, 5'd4, 1, 3), 0, 1, 32'hFFFF_FF80, 32'h100, 4'b1000, 32'h0);
    tbl[2]  = ve(vi(0, 1, 3'b100, 32'h103, 32'h0,         32'h80FF_1234, 5'd4, 1, 3), 0, 1, 32'h0000_0080, 32'h100, 4'b1000, 32'h0);
    tbl[3]  = ve(vi(1, 0, 3'b001, 32'h202, 32'h0000_BEEF, 32'h0,         5'd6, 1, 1), 0, 0, 32'h0,         32'h200, 4'b1100, 32'hBEEF_BEEF);
    tbl[4]  = ve(vi(0, 1, 3'b010, 32'h101, 32'h0,         32'h0,         5'd7, 1, 0), 1, 0, 32'h0,         32'h0,   4'h0,    32'h0);
    tbl[5]  = ve(vi(0, 0, 3'b000, 32'h0,   32'h1234_5678, 32'h0,         5'd0, 1, 0), 0, 0, 32'h0,         32'h0,   4'h0,    32'h0);
    tbl[6]  = ve(vi(0, 1, 3'b001, 32'h102, 32'h0,         32'h80FF_1234, 5'd8, 1, 0), 0, 1, 32'hFFFF_80FF, 32'h100, 4'b1100, 32'h0);
    tbl[7]  = ve(vi(0, 1, 3'b101, 32'h102, 32'h0,         32'h80FF_1234, 5'd8, 1, 2), 0, 1, 32'h0000_80FF, 32'h100, 4'b1100, 32'h0);
    tbl[8]  = ve(vi(1, 0, 3'b000, 32'h101, 32'h1234_56AB, 32'h0,         5'd9, 1, 0), 0, 0, 32'h0,         32'h100, 4'b0010, 32'hABAB_ABAB);
    tbl[9]  = ve(vi(1, 0, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0,         5'd9, 1, 1), 0, 0, 32'h0,         32'h104, 4'b1111, 32'hDEAD_BEEF);
    tbl[10] = ve(vi(0, 1, 3'b010, 32'h100, 32'h0,         32'hCAFE_F00D, 5'd5, 0, 1), 0, 0, 32'h0,         32'h100, 4'b1111, 32'h0);
    tbl[11] = ve(vi(1, 0, 3'b001, 32'h203, 32'h0000_1111, 32'h0,         5'd5, 1, 0), 1, 0, 32'h0,         32'h0,   4'h0,    32'h0);

    // Reset state
    step();
    step();
    chk("rst_ready", {31'd0, wb_ready_out}, 32'd1);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dwe", {31'd0, dmem_we}, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_daddr", dmem_addr, 32'd0);
    chk("rst_dwdata", dmem_wdata, 32'd0);
    chk("rst_we", {31'd0, reg_we}, 32'd0);
    chk("rst_waddr", {27'd0, reg_waddr}, 32'd0);
    chk("rst_wdata", reg_wdata, 32'd0);
    chk("rst_mis", {31'd0, wb_misaligned}, 32'd0);
    resetb = 1'b0;
    step();

    for (int i = 0; i < 12; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Next instruction presented while busy must wait until IDLE
    wait_ready("hold");
    drive(vi(0, 1, 3'b010, 32'h300, 32'h0, 32'h0, 5'd7, 1, 0));
    wb_valid_in = 1'b1;
    step();
    drive(vi(0, 0, 3'b000, 32'h0, 32'h0000_0077, 32'h0, 5'd5, 1, 0));
    for (int i = 0; i < 2; i++) begin
      chk("hold_busy_we", {31'd0, reg_we}, 32'd0);
      chk("hold_busy_ready", {31'd0, wb_ready_out}, 32'd0);
      step();
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1357_9BDF;
    step();
    dmem_ack = 1'b0;
    chk("hold_ld_we", {31'd0, reg_we}, 32'd1);
    chk("hold_ld_waddr", {27'd0, reg_waddr}, 32'd7);
    chk("hold_ld_wdata", reg_wdata, 32'h1357_9BDF);
    step();
    chk("hold_idle_we", {31'd0, reg_we}, 32'd0);
    chk("hold_idle_ready", {31'd0, wb_ready_out}, 32'd1);
    step();
    wb_valid_in = 1'b0;
    chk("hold_add_we", {31'd0, reg_we}, 32'd1);
    chk("hold_add_waddr", {27'd0, reg_waddr}, 32'd5);
    chk("hold_add_wdata", reg_wdata, 32'h0000_0077);
    step();

    // Reset during MEM_REQ with a coincident ack aborts the load
    drive(vi(0, 1, 3'b010, 32'h400, 32'h0, 32'h0, 5'd9, 1, 0));
    wb_valid_in = 1'b1;
    step();
    wb_valid_in = 1'b0;
    chk("abort_req", {31'd0, dmem_req}, 32'd1);
    step();
    resetb = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    step();
    chk("abort_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("abort_we", {31'd0, reg_we}, 32'd0);
    chk("abort_ready", {31'd0, wb_ready_out}, 32'd1);
    resetb = 1'b0;
    step();
    dmem_ack = 1'b0;
    chk("abort_we2", {31'd0, reg_we}, 32'd0);
    chk("abort_req2", {31'd0, dmem_req}, 32'd0);
    chk("abort_ready2", {31'd0, wb_ready_out}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      int op;
      logic [2:0] f3;
      op = int'($urandom_range(0, 2));
      if (op == 1) begin
        case ($urandom_range(0, 5))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
          3: f3 = 3'b100; 4: f3 = 3'b101; default: f3 = 3'b011;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 2));
      end
      rv = vi(op == 2, op == 1, f3, $urandom, $urandom, $urandom,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
              $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)));
      run_vec($sformatf("rnd%0d", i), model(rv));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_writeback
`default_nettype wire

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetb  input  1  reset; synchronous, active-high (1 = reset), sampled on clk rising edge.
REQ-003 SHALL have port wb_valid_in  input  1  execute stage presents a valid instruction result.
REQ-004 SHALL have port wb_ready_out  output  1  writeback accepts a new instruction this cycle.
REQ-005 SHALL have ports ex_result  input  32 (ALU/link/store data) and ex_addr  input  32 (load/store byte address).
REQ-006 SHALL have ports ex_memwr  input  1 (store), ex_mem2reg  input  1 (load), ex_funct3  input  3 (access size/sign), ex_dst_sel  input  5 (rd), ex_wb_en  input  1 (instruction writes rd).
REQ-007 SHALL have ports dmem_req  output  1, dmem_we  output  1, dmem_addr  output  32 (word-aligned), dmem_wdata  output  32, dmem_be  output  4, dmem_ack  input  1, dmem_rdata  input  32.
REQ-008 SHALL have ports reg_we  output  1, reg_waddr  output  5, reg_wdata  output  32 (register-file write port).
REQ-009 SHALL have port wb_misaligned  output  1  one-cycle pulse on misaligned load/store.

Function
REQ-010 SHALL accept an instruction only on wb_valid_in=1 and wb_ready_out=1 (transfer cycle).
REQ-011 SHALL implement FSM states IDLE, MEM_REQ, DONE; wb_ready_out=1 only in IDLE.
REQ-012 Non-memory transfer (ex_memwr=0, ex_mem2reg=0): SHALL stay in IDLE and assert reg_we with reg_wdata=ex_result, reg_waddr=ex_dst_sel in the next cycle (latency 1).
REQ-013 Aligned memory transfer: IDLE->MEM_REQ; dmem_req SHALL be 1 from next cycle, held with dmem_addr={ex_addr[31:2],2'b00}, dmem_we, dmem_be, dmem_wdata stable until dmem_ack=1 is sampled.
REQ-014 dmem_ack SHALL be ignored when dmem_req=0; ack in the first dmem_req cycle is legal.
REQ-015 On ack: MEM_REQ->DONE; in DONE, loads SHALL assert reg_we one cycle with formatted dmem_rdata; stores SHALL not write; DONE->IDLE unconditionally.
REQ-016 Load formatting by funct3/ex_addr[1:0]: 000 LB sign-ext byte, 001 LH sign-ext half, 010 LW word, 100 LBU zero-ext, 101 LHU zero-ext; other funct3 treated as LW.
REQ-017 Store encoding: SB be=4'b0001<<addr[1:0], wdata byte replicated x4; SH be=4'b0011 (addr[1]=0) or 4'b1100, half replicated x2; SW be=4'b1111.
REQ-018 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): SHALL issue no dmem_req, no reg_we, pulse wb_misaligned next cycle, remain in IDLE.
REQ-019 reg_we SHALL be 0 whenever rd=0 or ex_wb_en=0, regardless of instruction type.
REQ-020 reg_we SHALL be a single-cycle pulse per retired instruction; never asserted in MEM_REQ.
REQ-021 Simultaneous wb_valid_in with ready=0 SHALL not be consumed; execute holds inputs.

Reset
REQ-022 On resetb=1: state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, reg_we=0, reg_waddr=0, reg_wdata=0, wb_misaligned=0; wb_ready_out=1 first cycle after reset.
REQ-023 Reset mid-transaction SHALL abort: request dropped same edge, pending ack ignored, no register write.

Structure
REQ-024 Shared package riscv_pkg SHALL hold funct3 load/store constants (LB..LHU, SB/SH/SW) and the FSM state type.
REQ-025 Combinational sub-module lsu_align SHALL produce dmem_be, dmem_wdata, load-formatted data and misaligned flag; writeback instantiates it once.

Verification
REQ-026 ADD result 0x0000_0005, rd=3 -> reg_we=1, reg_waddr=3, reg_wdata=0x5 one cycle after transfer.
REQ-027 LB addr 0x103, dmem_rdata 0x80FF_1234, ack after 3 cycles -> reg_wdata=0xFFFF_FF80; LBU same -> 0x0000_0080; ready low throughout.
REQ-028 SH addr 0x202, data 0x0000_BEEF -> dmem_addr=0x200, be=4'b1100, wdata=0xBEEF_BEEF, no reg_we.
REQ-029 LW addr 0x101 -> wb_misaligned pulse, dmem_req never 1, reg_we=0.
REQ-030 ADD to rd=0 -> reg_we=0; reset asserted during MEM_REQ then ack=1 -> no reg_we, dmem_req=0, ready=1 after reset.
